// File: rtl/gemac_regs_pkg.sv
// GEMAC Wishbone register map, MII command codes and PHY register numbers
// shared by the PHY bring-up sequencer.
package gemac_regs_pkg;

    localparam logic [7:0] REG_MII_MODER  = 8'h14;
    localparam logic [7:0] REG_MII_ADDR   = 8'h18;
    localparam logic [7:0] REG_MII_TXDATA = 8'h1C;
    localparam logic [7:0] REG_MII_CMD    = 8'h20;
    localparam logic [7:0] REG_MII_STATUS = 8'h24;
    localparam logic [7:0] REG_MII_RXDATA = 8'h28;

    localparam logic [31:0] CMD_RSTAT     = 32'd2;
    localparam logic [31:0] CMD_WCTRLDATA = 32'd4;

    localparam int STATUS_BUSY_BIT = 1;

    localparam logic [4:0] PHY_REG_STATUS = 5'd1;
    localparam logic [4:0] PHY_REG_HWCFG  = 5'd27;

    typedef enum logic [1:0] {
        OP_WR   = 2'd0,
        OP_RD   = 2'd1,
        OP_POLL = 2'd2
    } op_kind_e;

    typedef struct packed {
        op_kind_e    kind;
        logic [7:0]  adr;
        logic [31:0] dat;
    } op_t;

    // MII ADDRESS register layout: register number in 12:8, PHY address in 4:0
    function automatic logic [31:0] mii_addr_word(input logic [4:0] reg_num, input logic [4:0] phy);
        return {19'd0, reg_num, 3'b000, phy};
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single-transfer Wishbone master: issues one access, waits for ack with a
// bounded cycle budget, and returns the low half-word of read data.
module wb_single_master #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [7:0]  req_adr,
    input  logic [31:0] req_dat,
    output logic        rsp_ack,
    output logic        rsp_timeout,
    output logic [15:0] rsp_data,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          cyc_r;
    logic          stb_r;
    logic          we_r;
    logic [7:0]    adr_r;
    logic [31:0]   dat_r;
    logic [TW-1:0] wait_cnt_r;
    logic          rsp_ack_r;
    logic          rsp_timeout_r;
    logic [15:0]   rsp_data_r;

    // Bus cycle control: launch on req, retire on ack or when the wait budget runs out
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r         <= 1'b0;
            stb_r         <= 1'b0;
            we_r          <= 1'b0;
            adr_r         <= 8'h00;
            dat_r         <= 32'h0000_0000;
            wait_cnt_r    <= '0;
            rsp_ack_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            rsp_data_r    <= 16'h0000;
        end else begin
            rsp_ack_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            if (cyc_r) begin
                if (wb_ack) begin
                    cyc_r      <= 1'b0;
                    stb_r      <= 1'b0;
                    we_r       <= 1'b0;
                    rsp_ack_r  <= 1'b1;
                    rsp_data_r <= wb_dat_i[15:0];
                end else if (wait_cnt_r == TW'(TIMEOUT)) begin
                    cyc_r         <= 1'b0;
                    stb_r         <= 1'b0;
                    we_r          <= 1'b0;
                    rsp_timeout_r <= 1'b1;
                end else begin
                    wait_cnt_r <= wait_cnt_r + TW'(1);
                end
            end else if (req) begin
                cyc_r      <= 1'b1;
                stb_r      <= 1'b1;
                we_r       <= req_we;
                adr_r      <= req_adr;
                dat_r      <= req_dat;
                wait_cnt_r <= '0;
            end
        end
    end

    assign wb_cyc      = cyc_r;
    assign wb_stb      = stb_r;
    assign wb_we       = we_r;
    assign wb_adr      = adr_r;
    assign wb_dat_o    = dat_r;
    assign rsp_ack     = rsp_ack_r;
    assign rsp_timeout = rsp_timeout_r;
    assign rsp_data    = rsp_data_r;

endmodule

// File: rtl/phy_init_seq.sv
// 88E1111 bring-up sequencer: pulses the PHY hard reset, then walks a fixed
// MDIO op table through the GEMAC Wishbone registers.
module phy_init_seq
    import gemac_regs_pkg::*;
#(
    parameter int         RST_CYCLES = 8388608,
    parameter int         MDC_DIV    = 24,
    parameter logic [4:0] PHY_ADDR   = 5'd7,
    parameter int         TIMEOUT    = 1023
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start,
    output logic        phy_reset_n,
    output logic        mac_rst,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] phy_status,
    output logic [15:0] hwcfg
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_PHY_RST    = 4'd1;
    localparam logic [3:0] ST_PHY_WAIT   = 4'd2;
    localparam logic [3:0] ST_OP_ISSUE   = 4'd3;
    localparam logic [3:0] ST_OP_ACK     = 4'd4;
    localparam logic [3:0] ST_POLL_ISSUE = 4'd5;
    localparam logic [3:0] ST_POLL_ACK   = 4'd6;
    localparam logic [3:0] ST_DONE       = 4'd7;
    localparam logic [3:0] ST_ERR        = 4'd8;

    localparam logic [3:0] LAST_IDX      = 4'd11;
    localparam logic [3:0] RD_STATUS_IDX = 4'd4;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]    state_r;
    logic [3:0]    op_idx_r;
    logic [RW-1:0] rst_cnt_r;
    logic [TW-1:0] poll_cnt_r;
    logic          phy_reset_n_r;
    logic          mac_rst_r;
    logic          busy_r;
    logic          done_r;
    logic          error_r;
    logic [15:0]   phy_status_r;
    logic [15:0]   hwcfg_r;

    op_t           op_s;
    logic          req_s;
    logic          req_we_s;
    logic [7:0]    req_adr_s;
    logic [31:0]   req_dat_s;
    logic          m_ack_s;
    logic          m_timeout_s;
    logic [15:0]   m_data_s;

    // Entry 10 rewrites reg 27 with the low nibble forced high, keeping the captured upper bits
    function automatic op_t op_entry(input logic [3:0] idx, input logic [11:0] hw_hi);
        op_t o;
        o.kind = OP_WR;
        o.adr  = 8'h00;
        o.dat  = 32'h0000_0000;
        case (idx)
            4'd0:  begin o.adr = REG_MII_MODER;  o.dat = 32'(MDC_DIV); end
            4'd1:  begin o.adr = REG_MII_ADDR;   o.dat = mii_addr_word(PHY_REG_STATUS, PHY_ADDR); end
            4'd2:  begin o.adr = REG_MII_CMD;    o.dat = CMD_RSTAT; end
            4'd3:  begin o.kind = OP_POLL;       o.adr = REG_MII_STATUS; end
            4'd4:  begin o.kind = OP_RD;         o.adr = REG_MII_RXDATA; end
            4'd5:  begin o.adr = REG_MII_ADDR;   o.dat = mii_addr_word(PHY_REG_HWCFG, PHY_ADDR); end
            4'd6:  begin o.adr = REG_MII_CMD;    o.dat = CMD_RSTAT; end
            4'd7:  begin o.kind = OP_POLL;       o.adr = REG_MII_STATUS; end
            4'd8:  begin o.kind = OP_RD;         o.adr = REG_MII_RXDATA; end
            4'd9:  begin o.adr = REG_MII_ADDR;   o.dat = mii_addr_word(PHY_REG_HWCFG, PHY_ADDR); end
            4'd10: begin o.adr = REG_MII_TXDATA; o.dat = {16'h0000, hw_hi, 4'b1111}; end
            4'd11: begin o.adr = REG_MII_CMD;    o.dat = CMD_WCTRLDATA; end
            default: begin o.kind = OP_WR; end
        endcase
        return o;
    endfunction

    // Current table entry and the request handed to the bus master
    always_comb begin
        op_s      = op_entry(op_idx_r, hwcfg_r[15:4]);
        req_s     = 1'b0;
        req_we_s  = 1'b0;
        req_adr_s = 8'h00;
        req_dat_s = 32'h0000_0000;
        if ((state_r == ST_OP_ISSUE) && (op_s.kind != OP_POLL)) begin
            req_s     = 1'b1;
            req_we_s  = (op_s.kind == OP_WR);
            req_adr_s = op_s.adr;
            req_dat_s = op_s.dat;
        end else if (state_r == ST_POLL_ISSUE) begin
            req_s     = 1'b1;
            req_adr_s = REG_MII_STATUS;
        end else begin
            req_s = 1'b0;
        end
    end

    wb_single_master #(
        .TIMEOUT (TIMEOUT)
    ) u_master (
        .clk         (wb_clk),
        .rst         (wb_rst),
        .req         (req_s),
        .req_we      (req_we_s),
        .req_adr     (req_adr_s),
        .req_dat     (req_dat_s),
        .rsp_ack     (m_ack_s),
        .rsp_timeout (m_timeout_s),
        .rsp_data    (m_data_s),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_adr      (wb_adr),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack      (wb_ack)
    );

    // Sequencer: reset timing, op table walk, busy polling and completion flags
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_r       <= ST_IDLE;
            op_idx_r      <= 4'd0;
            rst_cnt_r     <= '0;
            poll_cnt_r    <= '0;
            phy_reset_n_r <= 1'b1;
            mac_rst_r     <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            phy_status_r  <= 16'h0000;
            hwcfg_r       <= 16'h0000;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        error_r       <= 1'b0;
                        busy_r        <= 1'b1;
                        phy_reset_n_r <= 1'b0;
                        mac_rst_r     <= 1'b1;
                        rst_cnt_r     <= '0;
                        state_r       <= ST_PHY_RST;
                    end
                end
                ST_PHY_RST: begin
                    if (rst_cnt_r == RW'(RST_CYCLES - 1)) begin
                        phy_reset_n_r <= 1'b1;
                        rst_cnt_r     <= '0;
                        state_r       <= ST_PHY_WAIT;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RW'(1);
                    end
                end
                ST_PHY_WAIT: begin
                    if (rst_cnt_r == RW'(RST_CYCLES - 1)) begin
                        mac_rst_r <= 1'b0;
                        op_idx_r  <= 4'd0;
                        state_r   <= ST_OP_ISSUE;
                    end else begin
                        rst_cnt_r <= rst_cnt_r + RW'(1);
                    end
                end
                ST_OP_ISSUE: begin
                    if (op_s.kind == OP_POLL) begin
                        poll_cnt_r <= '0;
                        state_r    <= ST_POLL_ISSUE;
                    end else begin
                        state_r <= ST_OP_ACK;
                    end
                end
                ST_OP_ACK: begin
                    if (m_ack_s) begin
                        if (op_s.kind == OP_RD) begin
                            if (op_idx_r == RD_STATUS_IDX) begin
                                phy_status_r <= m_data_s;
                            end else begin
                                hwcfg_r <= m_data_s;
                            end
                        end
                        if (op_idx_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                        end else begin
                            op_idx_r <= op_idx_r + 4'd1;
                            state_r  <= ST_OP_ISSUE;
                        end
                    end else if (m_timeout_s) begin
                        state_r <= ST_ERR;
                    end
                end
                ST_POLL_ISSUE: begin
                    state_r <= ST_POLL_ACK;
                end
                ST_POLL_ACK: begin
                    if (m_ack_s) begin
                        if (!m_data_s[STATUS_BUSY_BIT]) begin
                            op_idx_r <= op_idx_r + 4'd1;
                            state_r  <= ST_OP_ISSUE;
                        end else if (poll_cnt_r == TW'(TIMEOUT)) begin
                            state_r <= ST_ERR;
                        end else begin
                            poll_cnt_r <= poll_cnt_r + TW'(1);
                            state_r    <= ST_POLL_ISSUE;
                        end
                    end else if (m_timeout_s) begin
                        state_r <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    error_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign phy_reset_n = phy_reset_n_r;
    assign mac_rst     = mac_rst_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign phy_status  = phy_status_r;
    assign hwcfg       = hwcfg_r;

endmodule

// File: tb/tb_phy_init_seq.sv
// Randomized bench for phy_init_seq: behavioural GEMAC slave, expected bus
// operations queued per run and matched by an independent monitor.
module tb_phy_init_seq;

    localparam int RST_N   = 16;
    localparam int TMO     = 31;
    localparam int PHY_A   = 7;
    localparam int MDC     = 24;
    localparam int BUSY_N  = 5;

    logic        wb_clk;
    logic        wb_rst;
    logic        start;
    logic        phy_reset_n;
    logic        mac_rst;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] phy_status;
    logic [15:0] hwcfg;

    typedef struct packed {
        logic [7:0]  adr;
        logic        we;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cycles = 0;

    logic [15:0] reg1_val;
    logic [15:0] reg27_val;
    logic [4:0]  cur_reg;
    logic [15:0] rx_data;
    int          busy_left = 0;
    bit          stuck_cmd = 0;
    bit          busy_stuck = 0;
    int          fixed_lat = 0;

    phy_init_seq #(
        .RST_CYCLES (RST_N),
        .MDC_DIV    (MDC),
        .PHY_ADDR   (5'd7),
        .TIMEOUT    (TMO)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst      (wb_rst),
        .start       (start),
        .phy_reset_n (phy_reset_n),
        .mac_rst     (mac_rst),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_adr      (wb_adr),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack      (wb_ack),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .phy_status  (phy_status),
        .hwcfg       (hwcfg)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_op(input logic [7:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        e.adr = a;
        e.we  = w;
        e.dat = d;
        exp_q.push_back(e);
    endtask

    // Full bring-up as seen on the bus: each MDIO read is command, BUSY_N+1 status polls, data read
    task automatic push_nominal(input logic [15:0] r27);
        push_op(8'h14, 1'b1, 32'(MDC));
        push_op(8'h18, 1'b1, 32'(1 * 256 + PHY_A));
        push_op(8'h20, 1'b1, 32'd2);
        repeat (BUSY_N + 1) push_op(8'h24, 1'b0, 32'd0);
        push_op(8'h28, 1'b0, 32'd0);
        push_op(8'h18, 1'b1, 32'(27 * 256 + PHY_A));
        push_op(8'h20, 1'b1, 32'd2);
        repeat (BUSY_N + 1) push_op(8'h24, 1'b0, 32'd0);
        push_op(8'h28, 1'b0, 32'd0);
        push_op(8'h18, 1'b1, 32'(27 * 256 + PHY_A));
        push_op(8'h1C, 1'b1, {16'h0000, (r27 & 16'hFFF0) | 16'h000F});
        push_op(8'h20, 1'b1, 32'd4);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_phy_reset_n"}, phy_reset_n, 1);
        chk({tag, "_mac_rst"}, mac_rst, 1);
        chk({tag, "_cyc_stb_we"}, {wb_cyc, wb_stb, wb_we}, 0);
        chk({tag, "_adr"}, wb_adr, 0);
        chk({tag, "_dat_o"}, wb_dat_o, 0);
        chk({tag, "_busy_done_err"}, {busy, done, error}, 0);
        chk({tag, "_phy_status"}, phy_status, 0);
        chk({tag, "_hwcfg"}, hwcfg, 0);
    endtask

    // Slave register behaviour applied at the ack cycle
    task automatic slave_access();
        logic [31:0] d;
        d = $urandom;
        if (wb_we) begin
            if (wb_adr == 8'h18) cur_reg = wb_dat_o[12:8];
            if (wb_adr == 8'h20 && wb_dat_o == 32'd2) begin
                rx_data   = (cur_reg == 5'd1) ? reg1_val : (cur_reg == 5'd27) ? reg27_val : 16'hDEAD;
                busy_left = BUSY_N;
            end
        end else if (wb_adr == 8'h24) begin
            d[1] = busy_stuck || (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end else if (wb_adr == 8'h28) begin
            d = {d[31:16], rx_data};
        end
        wb_dat_i = d;
    endtask

    // Behavioural GEMAC slave: ack after 1-3 cycles, optionally never acking the command write
    initial begin
        wb_ack   = 1'b0;
        wb_dat_i = 32'h0;
        cur_reg  = 5'd0;
        rx_data  = 16'h0;
        forever begin
            @(posedge wb_clk);
            #1;
            if (wb_cyc && wb_stb && !wb_rst) begin
                int  lat;
                bit  alive;
                lat   = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
                alive = 1'b1;
                for (int i = 1; i < lat; i++) begin
                    @(posedge wb_clk);
                    #1;
                    if (!wb_cyc) begin
                        alive = 1'b0;
                        break;
                    end
                end
                if (alive && stuck_cmd && wb_we && wb_adr == 8'h20) begin
                    for (int i = 0; i < 200 && wb_cyc; i++) begin
                        @(posedge wb_clk);
                        #1;
                    end
                end else if (alive) begin
                    slave_access();
                    wb_ack = 1'b1;
                    @(posedge wb_clk);
                    #1;
                    wb_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: every acked bus op is matched against the head of the expected queue
    initial begin
        bit   ack_prev;
        exp_t e;
        ack_prev = 1'b0;
        forever begin
            @(negedge wb_clk);
            if (ack_prev) chk("cyc_drop_after_ack", wb_cyc, 0);
            ack_prev = 1'b0;
            if (done) done_cycles++;
            if (wb_cyc && wb_stb && wb_ack) begin
                ack_prev = 1'b1;
                chk("bus_op_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bus_op_adr", wb_adr, e.adr);
                    chk("bus_op_we", wb_we, e.we);
                    if (e.we) chk("bus_op_wdata", wb_dat_o, e.dat);
                end
            end
        end
    end

    task automatic run_seq(input logic [15:0] r1, input logic [15:0] r27, input bit poke);
        int k;
        int t;
        int d0;
        bit poked;
        reg1_val  = r1;
        reg27_val = r27;
        push_nominal(r27);
        d0 = done_cycles;
        start = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        chk("start_error_cleared", error, 0);
        chk("start_busy_set", busy, 1);
        k = 0;
        while (phy_reset_n == 1'b0 && k < 100) begin
            k++;
            start = poke && (k == 5);
            @(negedge wb_clk);
        end
        start = 1'b0;
        chk("phy_reset_low_cycles", k, RST_N);
        k = 0;
        while (mac_rst == 1'b1 && k < 100) begin
            k++;
            start = poke && (k == 3);
            @(negedge wb_clk);
        end
        start = 1'b0;
        chk("phy_wait_high_cycles", k, RST_N);
        chk("phy_reset_n_released", phy_reset_n, 1);
        t = 0;
        poked = 1'b0;
        while (busy && t < 3000) begin
            t++;
            start = 1'b0;
            if (poke && !poked && wb_cyc) begin
                start = 1'b1;
                poked = 1'b1;
            end
            @(negedge wb_clk);
        end
        start = 1'b0;
        chk("seq_finished_in_time", t < 3000, 1);
        @(negedge wb_clk);
        @(negedge wb_clk);
        chk("done_pulse_cycles", done_cycles - d0, 1);
        chk("phy_status_value", phy_status, r1);
        chk("hwcfg_value", hwcfg, r27);
        chk("error_after_seq", error, 0);
        chk("mac_rst_after_seq", mac_rst, 0);
        chk("all_ops_seen", exp_q.size(), 0);
    endtask

    initial begin
        int          k;
        int          d0;
        logic [15:0] ra;
        logic [15:0] rb;
        wb_rst = 1'b1;
        start  = 1'b0;
        repeat (3) @(negedge wb_clk);
        check_reset_vals("reset");
        wb_rst = 1'b0;
        @(negedge wb_clk);

        run_seq(16'h796D, 16'h848B, 1'b0);

        ra = 16'($urandom);
        rb = 16'($urandom);
        run_seq(ra, rb, 1'b1);

        // Spurious ack with the bus idle must not start anything
        wb_ack = 1'b1;
        @(negedge wb_clk);
        wb_ack = 1'b0;
        k = 0;
        repeat (20) begin
            @(negedge wb_clk);
            if (wb_cyc || busy) k++;
        end
        chk("spurious_ack_idle", k, 0);
        chk("spurious_ack_status_kept", phy_status, ra);

        // Command write never acked
        stuck_cmd = 1'b1;
        d0 = done_cycles;
        push_op(8'h14, 1'b1, 32'(MDC));
        push_op(8'h18, 1'b1, 32'(1 * 256 + PHY_A));
        start = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        k = 0;
        while (!(wb_cyc && wb_we && wb_adr == 8'h20) && k < 500) begin
            k++;
            @(negedge wb_clk);
        end
        chk("ack_tmo_cmd_issued", k < 500, 1);
        k = 0;
        while (wb_cyc && k < 100) begin
            k++;
            @(negedge wb_clk);
        end
        chk("ack_tmo_bus_cycles", k, TMO + 1);
        repeat (3) @(negedge wb_clk);
        chk("ack_tmo_error", error, 1);
        chk("ack_tmo_busy", busy, 0);
        chk("ack_tmo_no_done", done_cycles - d0, 0);
        chk("ack_tmo_bus_idle", {wb_cyc, wb_stb, wb_we}, 0);
        chk("ack_tmo_ops", exp_q.size(), 0);
        chk("ack_tmo_status_kept", phy_status, ra);
        stuck_cmd = 1'b0;

        // Busy bit never clears
        busy_stuck = 1'b1;
        reg1_val = 16'($urandom);
        push_op(8'h14, 1'b1, 32'(MDC));
        push_op(8'h18, 1'b1, 32'(1 * 256 + PHY_A));
        push_op(8'h20, 1'b1, 32'd2);
        repeat (TMO + 1) push_op(8'h24, 1'b0, 32'd0);
        start = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        k = 0;
        while (busy && k < 5000) begin
            k++;
            @(negedge wb_clk);
        end
        repeat (3) @(negedge wb_clk);
        chk("poll_tmo_finished", k < 5000, 1);
        chk("poll_tmo_error", error, 1);
        chk("poll_tmo_no_done", done_cycles - d0, 0);
        chk("poll_tmo_poll_count", exp_q.size(), 0);
        chk("poll_tmo_hwcfg_kept", hwcfg, rb);
        busy_stuck = 1'b0;
        busy_left  = 0;

        run_seq(16'($urandom), 16'($urandom), 1'b0);

        // Reset while the reg27 data read is on the bus
        fixed_lat = 3;
        reg1_val  = 16'($urandom);
        reg27_val = 16'($urandom);
        push_nominal(reg27_val);
        start = 1'b1;
        @(negedge wb_clk);
        start = 1'b0;
        k = 0;
        while (!(wb_cyc && wb_stb && !wb_we && wb_adr == 8'h28 && !wb_ack && exp_q.size() == 4) && k < 4000) begin
            k++;
            @(negedge wb_clk);
        end
        chk("midop_read_reached", k < 4000, 1);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        check_reset_vals("midop_reset");
        wb_rst = 1'b0;
        exp_q.delete();
        fixed_lat = 0;
        k = 0;
        repeat (200) begin
            @(negedge wb_clk);
            if (wb_cyc || busy) k++;
        end
        chk("midop_no_resume", k, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
